matrix_add_engine: RTL and testbench

//   Vector/matrix element-wise add accelerator for the mini shader GPU. On a start pulse it

---
 rtl/matrix_add_engine.sv | 130 +++++++++++++
 tb/tb_matrix_add_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_add_engine.sv
// Element-wise C = A + B streaming engine: LANES scratchpad elements per cycle,
// with one lane datapath instance per scratchpad port lane.

module matrix_add_lane #(
   parameter int LANE   = 0,
   parameter int ADDR_W = 8,
   parameter int WORD_W = 32
) (
   input  logic              run,
   input  logic [31:0]       idx,
   input  logic [31:0]       length,
   input  logic [31:0]       base_a,
   input  logic [31:0]       base_b,
   input  logic [31:0]       base_c,
   input  logic [WORD_W-1:0] rdata_a,
   input  logic [WORD_W-1:0] rdata_b,
   output logic [ADDR_W-1:0] raddr_a,
   output logic [ADDR_W-1:0] raddr_b,
   output logic [ADDR_W-1:0] waddr,
   output logic [WORD_W-1:0] wdata,
   output logic              wen
);
   logic [31:0] e;
   logic        active;

   // Addresses are formed at 32 bits and truncated, so regions wrap at the scratchpad end.
   always_comb begin
      e       = idx + 32'(LANE);
      active  = run && (e < length);
      raddr_a = active ? ADDR_W'(base_a + e) : '0;
      raddr_b = active ? ADDR_W'(base_b + e) : '0;
      waddr   = active ? ADDR_W'(base_c + e) : '0;
      wdata   = active ? rdata_a + rdata_b : '0;
      wen     = active;
   end
endmodule

module matrix_add_engine #(
   parameter int LANES     = 4,
   parameter int MEM_DEPTH = 256,
   parameter int WORD_W    = 32,
   localparam int ADDR_W   = $clog2(MEM_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [31:0]                   baseA,
   input  logic [31:0]                   baseB,
   input  logic [31:0]                   baseC,
   input  logic [31:0]                   length,
   output logic                          busy,
   output logic                          done,
   output logic [LANES-1:0][ADDR_W-1:0]  mem_raddrA,
   output logic [LANES-1:0][ADDR_W-1:0]  mem_raddrB,
   input  logic [LANES-1:0][WORD_W-1:0]  mem_rdataA,
   input  logic [LANES-1:0][WORD_W-1:0]  mem_rdataB,
   output logic [LANES-1:0]              mem_wen,
   output logic [LANES-1:0][ADDR_W-1:0]  mem_waddr,
   output logic [LANES-1:0][WORD_W-1:0]  mem_wdata
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [31:0] idx, base_a, base_b, base_c, len_q;
   logic [32:0] next_idx;

   // One bit wider so the end-of-run compare cannot be fooled by idx wrap.
   assign next_idx = {1'b0, idx} + 33'(LANES);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         base_a <= '0;
         base_b <= '0;
         base_c <= '0;
         len_q  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               base_a <= baseA;
               base_b <= baseB;
               base_c <= baseC;
               len_q  <= length;
               idx    <= '0;
               if (length != 0) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            RUN: begin
               idx <= next_idx[31:0];
               if (next_idx >= {1'b0, len_q}) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      matrix_add_lane #(.LANE(l), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_lane (
         .run     (state == RUN),
         .idx     (idx),
         .length  (len_q),
         .base_a  (base_a),
         .base_b  (base_b),
         .base_c  (base_c),
         .rdata_a (mem_rdataA[l]),
         .rdata_b (mem_rdataB[l]),
         .raddr_a (mem_raddrA[l]),
         .raddr_b (mem_raddrB[l]),
         .waddr   (mem_waddr[l]),
         .wdata   (mem_wdata[l]),
         .wen     (mem_wen[l])
      );
   end
endmodule

// File: tb/tb_matrix_add_engine.sv
// Scoreboard bench: a sequential reference model queues expected writes,
// a negedge monitor checks every write the engine commits to the scratchpad.

module tb_matrix_add_engine;
   localparam int LANES = 4;
   localparam int DEPTH = 256;
   localparam int AW    = 8;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [31:0] baseA = '0, baseB = '0, baseC = '0, length = '0;
   logic busy, done;
   logic [LANES-1:0][AW-1:0] raddrA, raddrB, waddr;
   logic [LANES-1:0][31:0]   rdataA, rdataB, wdata;
   logic [LANES-1:0]         wen;

   logic [31:0] mem [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   wr_t sb[$];
   int n_cmp = 0, n_fail = 0;
   bit mon_en = 0;

   matrix_add_engine #(.LANES(LANES), .MEM_DEPTH(DEPTH), .WORD_W(32)) dut (
      .clk(clk), .rst(rst), .start(start),
      .baseA(baseA), .baseB(baseB), .baseC(baseC), .length(length),
      .busy(busy), .done(done),
      .mem_raddrA(raddrA), .mem_raddrB(raddrB),
      .mem_rdataA(rdataA), .mem_rdataB(rdataB),
      .mem_wen(wen), .mem_waddr(waddr), .mem_wdata(wdata)
   );

   always #5 clk = ~clk;

   // Scratchpad: combinational reads, writes commit at posedge.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         rdataA[l] = mem[raddrA[l]];
         rdataB[l] = mem[raddrB[l]];
      end
   end

   always @(posedge clk) begin
      for (int l = 0; l < LANES; l++)
         if (wen[l]) mem[waddr[l]] <= wdata[l];
   end

   always @(negedge clk) begin
      wr_t x;
      if (mon_en) begin
         for (int l = 0; l < LANES; l++) begin
            if (wen[l]) begin
               n_cmp++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_write lane %0d addr %0d data %0h", l, waddr[l], wdata[l]);
               end else begin
                  x = sb.pop_front();
                  if (waddr[l] !== x.addr || wdata[l] !== x.data) begin
                     n_fail++;
                     $display("FAIL write lane %0d: got addr %0d data %0h, expected addr %0d data %0h",
                              l, waddr[l], wdata[l], x.addr, x.data);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic setmem(input int a, input logic [31:0] v);
      mem[a] = v;
      ref_mem[a] = v;
   endtask

   // Reference: element i reads A[i], B[i] then writes C[i], in ascending order.
   task automatic model(input int ba, input int bb, input int bc, input int n);
      wr_t x;
      for (int i = 0; i < n; i++) begin
         x.addr = AW'((bc + i) % DEPTH);
         x.data = ref_mem[(ba + i) % DEPTH] + ref_mem[(bb + i) % DEPTH];
         ref_mem[(bc + i) % DEPTH] = x.data;
         sb.push_back(x);
      end
   endtask

   task automatic run_job(input int ba, input int bb, input int bc, input int n, input bit poke);
      int cyc;
      logic [LANES-1:0] lw;
      logic [LANES-1:0][AW-1:0] fra;
      lw = '0;
      fra = '0;
      model(ba, bb, bc, n);
      @(negedge clk);
      baseA = ba; baseB = bb; baseC = bc; length = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 200) begin
         if (cyc == 0) fra = raddrA;
         lw = wen;
         if (poke && cyc == 1) begin
            start = 1'b1; baseA = 200; length = 3;
         end else start = 1'b0;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_cycles", cyc, (n + LANES - 1) / LANES);
      chk("done_pulse", done, 1);
      chk("busy_after", busy, 0);
      if (n > 0) begin
         chk("last_wen", 32'(lw), (n % LANES == 0) ? 32'hF : (32'd1 << (n % LANES)) - 1);
         for (int l = 0; l < LANES; l++)
            chk("first_raddrA", 32'(fra[l]), (l < n) ? 32'((ba + l) % DEPTH) : 32'd0);
      end
      @(negedge clk);
      chk("done_single", done, 0);
      chk("sb_drained", sb.size(), 0);
      chk("idle_wen", 32'(wen), 0);
   endtask

   initial begin
      int nbad, ba, n;
      for (int i = 0; i < DEPTH; i++) setmem(i, 0);
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wen", 32'(wen), 0);
      chk("rst_raddrA", 32'(raddrA), 0);
      chk("rst_waddr", 32'(waddr), 0);
      rst = 1'b0;
      mon_en = 1;

      for (int i = 0; i < 8; i++) begin
         setmem(i, i + 1);
         setmem(16 + i, 10 * (i + 1));
      end
      run_job(0, 16, 32, 8, 0);
      for (int i = 0; i < 8; i++) chk("basic_c", mem[32 + i], 11 * (i + 1));

      setmem(46, 999); setmem(47, 999);
      run_job(0, 16, 40, 6, 0);
      chk("len6_keep46", mem[46], 999);
      chk("len6_keep47", mem[47], 999);
      chk("len6_c5", mem[45], 66);

      run_job(0, 16, 48, 0, 0);

      setmem(100, 32'hFFFF_FFFF); setmem(120, 1);
      run_job(100, 120, 140, 1, 0);
      chk("wrap_sum", mem[140], 0);
      run_job(DEPTH - 2, 16, 60, 4, 0);

      run_job(0, 16, 0, 8, 1);
      chk("inplace_a3", mem[3], 44);
      chk("start_ignored_c200", mem[200], 0);

      // Abort after one busy cycle: only the first four results may land.
      model(0, 16, 64, 4);
      @(negedge clk);
      baseA = 0; baseB = 16; baseC = 64; length = 16; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("abort_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy_off", busy, 0);
      for (int k = 0; k < 3; k++) begin
         chk("abort_no_done", done, 0);
         @(negedge clk);
      end
      chk("abort_sb", sb.size(), 0);
      chk("abort_c4", mem[68], 0);
      run_job(0, 16, 64, 16, 0);

      for (int i = 0; i < DEPTH; i++) setmem(i, $urandom);
      for (int j = 0; j < 8; j++) begin
         ba = $urandom_range(DEPTH - 1);
         n = $urandom_range(20);
         if (j % 3 == 2) run_job(ba, ba + 64, ba, n, 0);
         else            run_job(ba, ba + 64, ba + 128, n, 0);
      end

      nbad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nbad++;
      chk("final_mem", nbad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
